// File: rtl/period_meter.sv
// Measures the period and high time of an asynchronous input in clk cycles.
// A capture needs two rising edges; an edge-free stretch of 2^WIDTH-1 cycles raises timeout.
module period_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s;
  logic                   sig_d;
  logic                   rise;

  state_t                 state;
  state_t                 state_nxt;
  logic [WIDTH-1:0]       per_cnt;
  logic [WIDTH-1:0]       hi_cnt;
  logic [WIDTH-1:0]       per_nxt;
  logic [WIDTH-1:0]       hi_nxt;
  logic                   capture;
  logic                   to_nxt;

  // Input synchronizer plus one delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sig_s;
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign busy  = (state == MEAS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping en overrides everything, including a coincident rise
  always_comb begin
    state_nxt = state;
    per_nxt   = per_cnt;
    hi_nxt    = hi_cnt;
    capture   = 1'b0;
    to_nxt    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      per_nxt   = '0;
      hi_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          per_nxt   = '0;
          hi_nxt    = '0;
        end
        ARM: begin
          if (rise) begin
            state_nxt = MEAS;
            per_nxt   = CNT_ONE;
            hi_nxt    = CNT_ONE;
          end
        end
        MEAS: begin
          if (rise) begin
            capture = 1'b1;
            per_nxt = CNT_ONE;
            hi_nxt  = CNT_ONE;
          end else if (per_cnt == CNT_MAX) begin
            state_nxt = ARM;
            per_nxt   = '0;
            hi_nxt    = '0;
            to_nxt    = 1'b1;
          end else begin
            per_nxt = per_cnt + CNT_ONE;
            hi_nxt  = hi_cnt + {{(WIDTH-1){1'b0}}, sig_s};
          end
        end
        default: begin
          state_nxt = IDLE;
          per_nxt   = '0;
          hi_nxt    = '0;
        end
      endcase
    end
  end

  // Counters and result registers; results change only alongside valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt   <= '0;
      hi_cnt    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      per_cnt <= per_nxt;
      hi_cnt  <= hi_nxt;
      valid   <= capture;
      timeout <= to_nxt;
      if (capture) begin
        period    <= per_cnt;
        high_time <= hi_cnt;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: a 16-bit instance for the periodic cases
// and an 8-bit instance for the full-range capture and timeout cases.
module tb_period_meter;

  logic        clk;
  logic        rst;
  logic        en16, sig16, en8, sig8;
  logic [15:0] period16, high16;
  logic        valid16, timeout16, busy16;
  logic [7:0]  period8, high8;
  logic        valid8, timeout8, busy8;

  int          n_tests;
  int          n_fail;
  int          cyc;
  int          last_v8;
  logic [31:0] exp16_q[$];
  logic [31:0] exp8_q[$];
  int          exp_to8_q[$];
  logic [31:0] e16, e8;
  int          eto;

  period_meter #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .sig_in(sig16),
    .period(period16), .high_time(high16), .valid(valid16),
    .timeout(timeout16), .busy(busy16)
  );

  period_meter #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .sig_in(sig8),
    .period(period8), .high_time(high8), .valid(valid8),
    .timeout(timeout8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Callers are always positioned 1 time unit after a rising clk edge
  task automatic hold16(input logic v, input int n);
    sig16 = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold8(input logic v, input int n);
    sig8 = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sq16(input int h, input int l, input int n);
    repeat (n) begin
      hold16(1'b1, h);
      hold16(1'b0, l);
    end
  endtask

  task automatic rearm16();
    en16 = 1'b0;
    hold16(1'b0, 3);
    en16 = 1'b1;
    hold16(1'b0, 4);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a result
  always @(negedge clk) begin
    if (valid16) begin
      if (exp16_q.size() == 0) begin
        chk("valid16_unexpected", 32'd1, 32'd0);
      end else begin
        e16 = exp16_q.pop_front();
        chk("period16", 32'(period16), 32'(e16[31:16]));
        chk("high16", 32'(high16), 32'(e16[15:0]));
      end
    end
    if (timeout16) chk("timeout16_unexpected", 32'd1, 32'd0);
    if (valid8) begin
      last_v8 = cyc;
      if (exp8_q.size() == 0) begin
        chk("valid8_unexpected", 32'd1, 32'd0);
      end else begin
        e8 = exp8_q.pop_front();
        chk("period8", 32'(period8), 32'(e8[31:16]));
        chk("high8", 32'(high8), 32'(e8[15:0]));
      end
    end
    if (timeout8) begin
      if (exp_to8_q.size() == 0) begin
        chk("timeout8_unexpected", 32'd1, 32'd0);
      end else begin
        eto = exp_to8_q.pop_front();
        chk("timeout8_delay", 32'(cyc - last_v8), 32'(eto));
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_v8 = 0;
    rst  = 1'b1;
    en16 = 1'b0;
    en8  = 1'b0;
    sig16 = 1'b0;
    sig8  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_period16", 32'(period16), 32'd0);
    chk("rst_high16", 32'(high16), 32'd0);
    chk("rst_valid16", 32'(valid16), 32'd0);
    chk("rst_timeout16", 32'(timeout16), 32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_period8", 32'(period8), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    rst = 1'b0;
    en16 = 1'b1;
    hold16(1'b0, 4);

    // Case 1: 10-cycle period, 4 high, 5 periods -> 4 captures
    repeat (4) exp16_q.push_back({16'd10, 16'd4});
    sq16(4, 6, 5);
    hold16(1'b0, 4);
    chk("c1_pending", 32'(exp16_q.size()), 32'd0);
    chk("c1_busy", 32'(busy16), 32'd1);

    // Case 2: toggle every clk, 8 rises -> 7 captures of 2/1
    rearm16();
    chk("c2_hold_period", 32'(period16), 32'd10);
    repeat (7) exp16_q.push_back({16'd2, 16'd1});
    sq16(1, 1, 8);
    hold16(1'b0, 4);
    chk("c2_pending", 32'(exp16_q.size()), 32'd0);

    // Case 4: en dropped mid-period, then two fresh rises needed
    rearm16();
    repeat (2) exp16_q.push_back({16'd10, 16'd4});
    sq16(4, 6, 2);
    hold16(1'b1, 4);
    hold16(1'b0, 2);
    en16 = 1'b0;
    hold16(1'b0, 3);
    chk("c4_idle_busy", 32'(busy16), 32'd0);
    chk("c4_hold_period", 32'(period16), 32'd10);
    en16 = 1'b1;
    hold16(1'b0, 4);
    repeat (2) exp16_q.push_back({16'd7, 16'd3});
    sq16(3, 4, 3);
    hold16(1'b0, 4);
    chk("c4_pending", 32'(exp16_q.size()), 32'd0);

    // Case 5: rst pulse mid-measurement after a 10-cycle capture
    rearm16();
    repeat (2) exp16_q.push_back({16'd10, 16'd4});
    sq16(4, 6, 2);
    hold16(1'b1, 4);
    hold16(1'b0, 2);
    chk("c5_pre_rst_period", 32'(period16), 32'd10);
    rst = 1'b1;
    #1;
    chk("c5_rst_period", 32'(period16), 32'd0);
    chk("c5_rst_high", 32'(high16), 32'd0);
    chk("c5_rst_busy", 32'(busy16), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold16(1'b0, 4);
    repeat (2) exp16_q.push_back({16'd6, 16'd4});
    sq16(4, 2, 3);
    hold16(1'b0, 4);
    chk("c5_pending", 32'(exp16_q.size()), 32'd0);
    en16 = 1'b0;

    // Case 6 then case 3 on the 8-bit instance
    en8 = 1'b1;
    hold8(1'b0, 4);
    exp8_q.push_back({16'd255, 16'd100});
    exp_to8_q.push_back(255);
    hold8(1'b1, 100);
    hold8(1'b0, 155);
    hold8(1'b1, 300);
    chk("c6_pending_valid", 32'(exp8_q.size()), 32'd0);
    chk("c3_pending_timeout", 32'(exp_to8_q.size()), 32'd0);
    chk("c3_busy_after", 32'(busy8), 32'd0);
    chk("c3_period_kept", 32'(period8), 32'd255);
    chk("c3_high_kept", 32'(high8), 32'd100);
    en8 = 1'b0;
    hold8(1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter WIDTH, default 16, sets the bit width of the period and high-time counters and outputs.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, sets the number of input synchronizer flops on sig_in.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  measurement enable; 0 forces IDLE.
REQ-006 sig_in  input  1  asynchronous periodic signal to measure.
REQ-007 period  output  WIDTH  clk cycles between the last two detected rising edges of sig_in.
REQ-008 high_time  output  WIDTH  clk cycles sig_in was high within that same period.
REQ-009 valid  output  1  single-cycle pulse; period/high_time were updated this cycle.
REQ-010 timeout  output  1  single-cycle pulse; no rising edge arrived within 2^WIDTH-1 cycles.
REQ-011 busy  output  1  high while in state MEAS.

Function
REQ-012 sig_in SHALL pass through SYNC_STAGES flops to give sig_s, then one further flop to give sig_d.
REQ-013 A rising edge (rise) SHALL be asserted combinationally in any cycle where sig_s=1 and sig_d=0.
REQ-014 The FSM SHALL have exactly three states: IDLE, ARM and MEAS.
REQ-015 IDLE -> ARM when en=1; ARM -> MEAS on rise; any state -> IDLE in the cycle after en=0.
REQ-016 In IDLE, per_cnt and hi_cnt SHALL be 0, and valid and timeout SHALL stay 0.
REQ-017 On rise in ARM, the block SHALL load per_cnt<=1 and hi_cnt<=1 and SHALL NOT assert valid.
REQ-018 In MEAS on a non-rise cycle, per_cnt SHALL increment by 1 and hi_cnt SHALL increment by sig_s.
REQ-019 On rise in MEAS, the block SHALL register period<=per_cnt, high_time<=hi_cnt and valid<=1, all visible on the next cycle.
REQ-020 On that same rise, the block SHALL reload per_cnt<=1 and hi_cnt<=1 and SHALL stay in MEAS.
REQ-021 Rises at cycles t0 and t0+P SHALL yield period=P, and high_time SHALL equal the count of sig_s=1 cycles in [t0, t0+P-1].
REQ-022 In MEAS, if per_cnt = 2^WIDTH-1 and there is no rise, the FSM SHALL go to ARM, clear the counters, pulse timeout for one cycle next cycle, and SHALL NOT assert valid.
REQ-023 If rise coincides with per_cnt = 2^WIDTH-1, rise SHALL win: a normal capture with period=2^WIDTH-1 and no timeout.
REQ-024 If en falls in the same cycle as a rise in MEAS, en SHALL win: no capture, no valid, the FSM goes to IDLE.
REQ-025 period and high_time SHALL hold their last captured values through IDLE, ARM and timeout, and change only with valid.
REQ-026 hi_cnt SHALL never exceed per_cnt; no saturation logic beyond REQ-022 is required.
REQ-027 The minimum measurable period SHALL be 2 (sig_s alternating 1,0), giving period=2 and high_time=1.
REQ-028 valid SHALL pulse once per rise in MEAS, so back-to-back valids occur no closer than 2 cycles apart.

Reset
REQ-029 While rst=1, all of the following SHALL hold: state=IDLE; synchronizer flops, sig_d, per_cnt, hi_cnt, period and high_time = 0; valid, timeout and busy = 0.
REQ-030 Assertion of rst in the middle of a measurement SHALL discard the partial measurement.
REQ-031 After rst is released with en=1, the first capture SHALL require two fresh rising edges.

Verification
REQ-032 Case 1: WIDTH=16, en=1, sig_in square wave with 10-cycle period and 4 cycles high, 5 periods -> the first valid appears after the 2nd rise; every valid shows period=10, high_time=4; exactly 4 valids.
REQ-033 Case 2: sig_in toggles every clk -> period=2 and high_time=1 on every valid.
REQ-034 Case 3: WIDTH=8, one rise then sig_in held high -> timeout pulses exactly 255 cycles after the rise is loaded; no valid; busy=0 afterwards; period is unchanged.
REQ-035 Case 4: en=0 in the middle of a period, then en=1 -> no valid for the aborted period; the next capture needs two new rises and is correct.
REQ-036 Case 5: rst pulsed for 1 cycle mid-MEAS after a prior capture of period=10 -> period=0 and high_time=0 immediately; recovery is as in REQ-031.
REQ-037 Case 6: WIDTH=8, rise exactly 255 cycles after the previous rise -> valid with period=255; timeout stays 0.
